zap_wb_arb: RTL

ZAP_WB_ARB -- requirements
Module: zap_wb_arb

---
 rtl/zap_wb_arb.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/zap_wb_arb.sv
// Two-port Wishbone arbiter: merges the I-cache (code) and D-cache (data)
// next-cycle request buses onto one registered shared bus, keeps a burst
// with its owner until the owner drops cyc, and routes ack/err back to the
// current owner only.
module zap_wb_arb #(
  parameter bit RR_EN = 1'b1  // 1: round-robin on contention, 0: data always wins
) (
  input  logic        i_clk,
  input  logic        i_reset_n,

  // Code port (I-cache) next-cycle request
  input  logic        i_c_wb_cyc_nxt,
  input  logic        i_c_wb_stb_nxt,
  input  logic        i_c_wb_wen_nxt,
  input  logic [3:0]  i_c_wb_sel_nxt,
  input  logic [31:0] i_c_wb_adr_nxt,
  input  logic [31:0] i_c_wb_dat_nxt,
  input  logic [2:0]  i_c_wb_cti_nxt,
  output logic        o_c_wb_ack,
  output logic        o_c_wb_err,

  // Data port (D-cache) next-cycle request
  input  logic        i_d_wb_cyc_nxt,
  input  logic        i_d_wb_stb_nxt,
  input  logic        i_d_wb_wen_nxt,
  input  logic [3:0]  i_d_wb_sel_nxt,
  input  logic [31:0] i_d_wb_adr_nxt,
  input  logic [31:0] i_d_wb_dat_nxt,
  input  logic [2:0]  i_d_wb_cti_nxt,
  output logic        o_d_wb_ack,
  output logic        o_d_wb_err,

  // Shared registered bus
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_wen,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [2:0]  o_wb_cti,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,

  // Grant state: 00 idle, 01 code, 10 data
  output logic [1:0]  o_gnt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CODE = 2'b01,
    DATA = 2'b10
  } state_t;

  state_t      r_state_ff;
  state_t      w_state_nxt;
  logic        r_last_ff;     // 1 = data was granted most recently, 0 = code

  logic        w_bus_free;

  logic        r_wb_cyc;
  logic        r_wb_stb;
  logic        r_wb_wen;
  logic [3:0]  r_wb_sel;
  logic [31:0] r_wb_adr;
  logic [31:0] r_wb_dat;
  logic [2:0]  r_wb_cti;

  logic        w_wb_cyc;
  logic        w_wb_stb;
  logic        w_wb_wen;
  logic [3:0]  w_wb_sel;
  logic [31:0] w_wb_adr;
  logic [31:0] w_wb_dat;
  logic [2:0]  w_wb_cti;

  // An error terminates a cycle just like an ack, so either frees the bus.
  assign w_bus_free = !r_wb_stb || i_wb_ack || i_wb_err;

  // Next grant: hold while a strobe is outstanding, keep a continuing owner,
  // otherwise hand the bus to whoever asks (contention resolved by RR_EN).
  always_comb begin
    w_state_nxt = r_state_ff;
    if (w_bus_free) begin
      if ((r_state_ff == CODE) && i_c_wb_cyc_nxt) begin
        w_state_nxt = CODE;
      end else if ((r_state_ff == DATA) && i_d_wb_cyc_nxt) begin
        w_state_nxt = DATA;
      end else if (i_c_wb_cyc_nxt && i_d_wb_cyc_nxt) begin
        w_state_nxt = (RR_EN && r_last_ff) ? CODE : DATA;
      end else if (i_c_wb_cyc_nxt) begin
        w_state_nxt = CODE;
      end else if (i_d_wb_cyc_nxt) begin
        w_state_nxt = DATA;
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

  // Payload mux for the shared bus, steered by the grant about to take effect.
  always_comb begin
    w_wb_cyc = 1'b0;
    w_wb_stb = 1'b0;
    w_wb_wen = 1'b0;
    w_wb_sel = 4'h0;
    w_wb_adr = 32'h0;
    w_wb_dat = 32'h0;
    w_wb_cti = 3'b111;
    case (w_state_nxt)
      CODE: begin
        w_wb_cyc = i_c_wb_cyc_nxt;
        w_wb_stb = i_c_wb_stb_nxt;
        w_wb_wen = i_c_wb_wen_nxt;
        w_wb_sel = i_c_wb_sel_nxt;
        w_wb_adr = i_c_wb_adr_nxt;
        w_wb_dat = i_c_wb_dat_nxt;
        w_wb_cti = i_c_wb_cti_nxt;
      end
      DATA: begin
        w_wb_cyc = i_d_wb_cyc_nxt;
        w_wb_stb = i_d_wb_stb_nxt;
        w_wb_wen = i_d_wb_wen_nxt;
        w_wb_sel = i_d_wb_sel_nxt;
        w_wb_adr = i_d_wb_adr_nxt;
        w_wb_dat = i_d_wb_dat_nxt;
        w_wb_cti = i_d_wb_cti_nxt;
      end
      default: begin
      end
    endcase
  end

  // Grant state and round-robin history; history only moves on a real grant.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state_ff <= IDLE;
      r_last_ff  <= 1'b0;
    end else begin
      r_state_ff <= w_state_nxt;
      if (w_state_nxt != IDLE) begin
        r_last_ff <= (w_state_nxt == DATA);
      end
    end
  end

  // Registered shared bus; reset drops cyc/stb immediately.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wb_cyc <= 1'b0;
      r_wb_stb <= 1'b0;
      r_wb_wen <= 1'b0;
      r_wb_sel <= 4'h0;
      r_wb_adr <= 32'h0;
      r_wb_dat <= 32'h0;
      r_wb_cti <= 3'b111;
    end else begin
      r_wb_cyc <= w_wb_cyc;
      r_wb_stb <= w_wb_stb;
      r_wb_wen <= w_wb_wen;
      r_wb_sel <= w_wb_sel;
      r_wb_adr <= w_wb_adr;
      r_wb_dat <= w_wb_dat;
      r_wb_cti <= w_wb_cti;
    end
  end

  assign o_wb_cyc = r_wb_cyc;
  assign o_wb_stb = r_wb_stb;
  assign o_wb_wen = r_wb_wen;
  assign o_wb_sel = r_wb_sel;
  assign o_wb_adr = r_wb_adr;
  assign o_wb_dat = r_wb_dat;
  assign o_wb_cti = r_wb_cti;
  assign o_gnt    = r_state_ff;

  // Responses go only to the current owner; in idle they are discarded.
  assign o_c_wb_ack = (r_state_ff == CODE) && i_wb_ack;
  assign o_c_wb_err = (r_state_ff == CODE) && i_wb_err;
  assign o_d_wb_ack = (r_state_ff == DATA) && i_wb_ack;
  assign o_d_wb_err = (r_state_ff == DATA) && i_wb_err;

endmodule
